// File: rtl/door_access_if.sv
// Bundle of per-door sensor/card inputs and LED/latch/occupancy outputs.
interface door_access_if #(
  parameter int unsigned NUM_DOORS = 2,
  parameter int unsigned CAP       = 2
);
  localparam int unsigned OCC_W = $clog2(CAP + 1);

  logic [NUM_DOORS-1:0] sensor_entrance;
  logic [NUM_DOORS-1:0] sensor_exit;
  logic [NUM_DOORS-1:0] card_valid;
  logic [NUM_DOORS-1:0] card_invalid;
  logic [NUM_DOORS-1:0] leave;
  logic [NUM_DOORS-1:0] GREEN_LED;
  logic [NUM_DOORS-1:0] RED_LED;
  logic [NUM_DOORS-1:0] door_status;
  logic [OCC_W-1:0]     occupancy;
  logic                 full;

  // Stimulus side: drives sensors and cards, observes indicators.
  modport master (
    output sensor_entrance, sensor_exit, card_valid, card_invalid, leave,
    input  GREEN_LED, RED_LED, door_status, occupancy, full
  );

  // Controller side.
  modport slave (
    input  sensor_entrance, sensor_exit, card_valid, card_invalid, leave,
    output GREEN_LED, RED_LED, door_status, occupancy, full
  );
endinterface

// File: rtl/door_access_ctrl.sv
// Multi-door access controller: per-door card FSMs sharing a capacity-limited
// occupancy counter. All outputs are registered.
module door_access_ctrl #(
  parameter int unsigned NUM_DOORS   = 2,
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned CAP         = 2
) (
  input logic         clk,
  input logic         reset,
  door_access_if.slave bus
);
  localparam int unsigned OCC_W = $clog2(CAP + 1);
  localparam int unsigned TMAX  = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW    = $clog2(TMAX);
  localparam int unsigned FW    = $clog2(MAX_FAILS + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OPEN, S_LOCK} state_t;

  state_t               state_q [NUM_DOORS];
  state_t               state_d [NUM_DOORS];
  logic [TW-1:0]        timer_q [NUM_DOORS];
  logic [TW-1:0]        timer_d [NUM_DOORS];
  logic [FW-1:0]        fail_q  [NUM_DOORS];
  logic [FW-1:0]        fail_d  [NUM_DOORS];
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [NUM_DOORS-1:0] grant, pass;
  logic [NUM_DOORS-1:0] green_q, red_q, status_q;
  logic                 full_q;

  // Slot arbitration, per-door next state and occupancy update.
  always_comb begin : next_state
    int unsigned used;
    int unsigned n_pass;
    int unsigned n_leave;
    int          occ_n;
    grant   = '0;
    pass    = '0;
    n_pass  = 0;
    n_leave = 0;
    // Doors already open hold a slot until they exit or time out.
    used = 32'(occ_q);
    for (int unsigned i = 0; i < NUM_DOORS; i++)
      if (state_q[i] == S_OPEN) used = used + 1;
    for (int unsigned i = 0; i < NUM_DOORS; i++) begin
      if (state_q[i] == S_WAIT && bus.sensor_entrance[i] && bus.card_valid[i] && used < CAP) begin
        grant[i] = 1'b1;
        used     = used + 1;
      end
    end
    for (int unsigned i = 0; i < NUM_DOORS; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      fail_d[i]  = fail_q[i];
      case (state_q[i])
        S_IDLE: if (bus.sensor_entrance[i]) state_d[i] = S_WAIT;
        S_WAIT: begin
          if (!bus.sensor_entrance[i]) begin
            state_d[i] = S_IDLE;
            fail_d[i]  = '0;
          end else if (bus.card_valid[i]) begin
            if (grant[i]) begin
              state_d[i] = S_OPEN;
              fail_d[i]  = '0;
              timer_d[i] = TW'(OPEN_CYCLES - 1);
            end
          end else if (bus.card_invalid[i]) begin
            fail_d[i] = fail_q[i] + 1'b1;
            if (32'(fail_q[i]) + 1 >= MAX_FAILS) begin
              state_d[i] = S_LOCK;
              timer_d[i] = TW'(LOCK_CYCLES - 1);
            end
          end
        end
        S_OPEN: begin
          // An exit on the expiry cycle still counts.
          if (bus.sensor_exit[i]) begin
            pass[i]    = 1'b1;
            state_d[i] = bus.sensor_entrance[i] ? S_WAIT : S_IDLE;
          end else if (timer_q[i] == '0) begin
            state_d[i] = S_IDLE;
          end else begin
            timer_d[i] = timer_q[i] - 1'b1;
          end
        end
        S_LOCK: begin
          if (timer_q[i] == '0) begin
            state_d[i] = S_IDLE;
            fail_d[i]  = '0;
          end else begin
            timer_d[i] = timer_q[i] - 1'b1;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
      if (pass[i])          n_pass  = n_pass + 1;
      if (bus.leave[i])     n_leave = n_leave + 1;
    end
    occ_n = int'(occ_q) + int'(n_pass) - int'(n_leave);
    if (occ_n < 0)        occ_n = 0;
    if (occ_n > int'(CAP)) occ_n = int'(CAP);
    occ_d = OCC_W'(occ_n);
  end

  // State, counters and output registers; outputs decode the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_DOORS; i++) begin
        state_q[i] <= S_IDLE;
        timer_q[i] <= '0;
        fail_q[i]  <= '0;
      end
      occ_q    <= '0;
      full_q   <= 1'b0;
      green_q  <= '0;
      red_q    <= '0;
      status_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_DOORS; i++) begin
        state_q[i]  <= state_d[i];
        timer_q[i]  <= timer_d[i];
        fail_q[i]   <= fail_d[i];
        green_q[i]  <= (state_d[i] == S_OPEN);
        status_q[i] <= (state_d[i] == S_OPEN);
        red_q[i]    <= (state_d[i] == S_WAIT) || (state_d[i] == S_LOCK);
      end
      occ_q  <= occ_d;
      full_q <= (32'(occ_d) == CAP);
    end
  end

  assign bus.GREEN_LED   = green_q;
  assign bus.RED_LED     = red_q;
  assign bus.door_status = status_q;
  assign bus.occupancy   = occ_q;
  assign bus.full        = full_q;
endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl with a countdown-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_door_access_ctrl;
  localparam int N    = 2;
  localparam int OPEN = 8;
  localparam int MAXF = 3;
  localparam int LOCK = 16;
  localparam int CAP  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  door_access_if #(.NUM_DOORS(N), .CAP(CAP)) bus ();

  door_access_ctrl #(
    .NUM_DOORS(N), .OPEN_CYCLES(OPEN), .MAX_FAILS(MAXF),
    .LOCK_CYCLES(LOCK), .CAP(CAP)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: a door is open while open_left>0, locked while lock_left>0,
  // waiting for a card while waiting=1, otherwise idle.
  int open_left [N];
  int lock_left [N];
  int fails     [N];
  bit waiting   [N];
  int m_occ;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_step();
    int used;
    int delta;
    bit gr [N];
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        open_left[i] = 0; lock_left[i] = 0; fails[i] = 0; waiting[i] = 0;
      end
      m_occ = 0;
      return;
    end
    used = m_occ;
    for (int i = 0; i < N; i++) if (open_left[i] > 0) used++;
    for (int i = 0; i < N; i++) begin
      gr[i] = 0;
      if (waiting[i] && bus.sensor_entrance[i] && bus.card_valid[i] && used < CAP) begin
        gr[i] = 1; used++;
      end
    end
    delta = 0;
    for (int i = 0; i < N; i++) begin
      if (bus.leave[i]) delta--;
      if (lock_left[i] > 0) begin
        lock_left[i]--;
        if (lock_left[i] == 0) fails[i] = 0;
      end else if (open_left[i] > 0) begin
        if (bus.sensor_exit[i]) begin
          delta++;
          open_left[i] = 0;
          waiting[i] = bus.sensor_entrance[i];
        end else begin
          open_left[i]--;
        end
      end else if (waiting[i]) begin
        if (!bus.sensor_entrance[i]) begin
          waiting[i] = 0; fails[i] = 0;
        end else if (bus.card_valid[i]) begin
          if (gr[i]) begin
            open_left[i] = OPEN; waiting[i] = 0; fails[i] = 0;
          end
        end else if (bus.card_invalid[i]) begin
          fails[i]++;
          if (fails[i] >= MAXF) begin
            lock_left[i] = LOCK; waiting[i] = 0;
          end
        end
      end else if (bus.sensor_entrance[i]) begin
        waiting[i] = 1;
      end
    end
    m_occ = m_occ + delta;
    if (m_occ < 0) m_occ = 0;
    if (m_occ > CAP) m_occ = CAP;
  endtask

  task automatic compare_model();
    logic [N-1:0] eg, er;
    for (int i = 0; i < N; i++) begin
      eg[i] = (open_left[i] > 0);
      er[i] = waiting[i] || (lock_left[i] > 0);
    end
    check("model_green",  32'(bus.GREEN_LED),   32'(eg));
    check("model_status", 32'(bus.door_status), 32'(eg));
    check("model_red",    32'(bus.RED_LED),     32'(er));
    check("model_occ",    32'(bus.occupancy),   32'(m_occ));
    check("model_full",   32'(bus.full),        32'(m_occ == CAP));
  endtask

  // One clock: model samples inputs on the edge, outputs compared mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic [N-1:0] ent, input logic [N-1:0] ext,
                       input logic [N-1:0] cv, input logic [N-1:0] ci,
                       input logic [N-1:0] lv);
    bus.sensor_entrance = ent;
    bus.sensor_exit     = ext;
    bus.card_valid      = cv;
    bus.card_invalid    = ci;
    bus.leave           = lv;
  endtask

  initial begin
    drive('0, '0, '0, '0, '0);
    reset = 1'b1;
    tick(); tick();
    check("rst_green", 32'(bus.GREEN_LED), 0);
    check("rst_red",   32'(bus.RED_LED), 0);
    check("rst_occ",   32'(bus.occupancy), 0);
    check("rst_full",  32'(bus.full), 0);
    reset = 1'b0;

    // Admit and pass through door 0.
    drive(2'b01, '0, '0, '0, '0); tick();
    check("t1_red0", 32'(bus.RED_LED[0]), 1);
    drive(2'b01, '0, 2'b01, '0, '0); tick();
    check("t1_green0", 32'(bus.GREEN_LED[0]), 1);
    check("t1_status0", 32'(bus.door_status[0]), 1);
    drive(2'b01, '0, '0, '0, '0); tick();
    drive('0, 2'b01, '0, '0, '0); tick();
    check("t1_occ", 32'(bus.occupancy), 1);
    check("t1_status0_closed", 32'(bus.door_status[0]), 0);

    // Door 0 opens, nobody walks through: exactly OPEN cycles.
    drive(2'b01, '0, '0, '0, '0); tick();
    drive(2'b01, '0, 2'b01, '0, '0); tick();
    check("t2_open_c1", 32'(bus.door_status[0]), 1);
    drive('0, '0, '0, '0, '0);
    for (int k = 0; k < OPEN - 1; k++) begin
      tick();
      check("t2_open_hold", 32'(bus.door_status[0]), 1);
    end
    tick();
    check("t2_timeout", 32'(bus.door_status[0]), 0);
    check("t2_occ", 32'(bus.occupancy), 1);

    // Door 1 lockout after three invalid cards.
    drive(2'b10, '0, '0, '0, '0); tick();
    for (int f = 0; f < MAXF; f++) begin
      drive(2'b10, '0, '0, 2'b10, '0); tick();
      if (f < MAXF - 1) begin
        drive(2'b10, '0, '0, '0, '0); tick();
      end
    end
    check("t3_lock_red", 32'(bus.RED_LED[1]), 1);
    drive(2'b10, '0, 2'b10, '0, '0);
    for (int k = 0; k < LOCK - 1; k++) begin
      tick();
      check("t3_lock_hold", 32'({bus.RED_LED[1], bus.GREEN_LED[1]}), 2);
    end
    tick();
    check("t3_lock_end", 32'({bus.RED_LED[1], bus.GREEN_LED[1]}), 0);
    drive('0, '0, '0, '0, '0); tick();

    // Two simultaneous cards with one free slot: lowest index wins.
    drive(2'b11, '0, '0, '0, '0); tick();
    drive(2'b11, '0, 2'b11, '0, '0); tick();
    check("t4_green0", 32'(bus.GREEN_LED[0]), 1);
    check("t4_green1", 32'(bus.GREEN_LED[1]), 0);
    check("t4_red1",   32'(bus.RED_LED[1]), 1);
    drive(2'b10, 2'b01, 2'b10, '0, '0); tick();
    check("t4_occ_full", 32'({bus.full, bus.occupancy}), 32'({1'b1, 2'd2}));
    check("t4_refused", 32'(bus.GREEN_LED[1]), 0);
    drive(2'b10, '0, 2'b10, '0, '0); tick();
    check("t4_still_wait", 32'({bus.RED_LED[1], bus.GREEN_LED[1]}), 2);

    // Leave frees a slot; held card then admits.
    drive(2'b10, '0, 2'b10, '0, 2'b01); tick();
    check("t5_occ", 32'({bus.full, bus.occupancy}), 32'({1'b0, 2'd1}));
    check("t5_not_yet", 32'(bus.GREEN_LED[1]), 0);
    drive(2'b10, '0, 2'b10, '0, '0); tick();
    check("t5_green1", 32'(bus.GREEN_LED[1]), 1);
    drive('0, 2'b10, '0, '0, '0); tick();
    check("t5_occ2", 32'(bus.occupancy), 2);
    drive('0, '0, '0, '0, '0); tick();

    // Reset while door 0 is open.
    drive('0, '0, '0, '0, 2'b01); tick();
    check("t6_occ1", 32'(bus.occupancy), 1);
    drive(2'b01, '0, '0, '0, '0); tick();
    drive(2'b01, '0, 2'b01, '0, '0); tick();
    check("t6_open", 32'(bus.door_status[0]), 1);
    drive(2'b01, '0, '0, '0, '0);
    reset = 1'b1; tick();
    check("t6_rst_status", 32'(bus.door_status), 0);
    check("t6_rst_occ",    32'(bus.occupancy), 0);
    check("t6_rst_leds",   32'({bus.GREEN_LED, bus.RED_LED}), 0);
    reset = 1'b0;
    drive('0, '0, '0, '0, 2'b01); tick();
    check("t6_leave_at0", 32'(bus.occupancy), 0);

    // Pass and leave on the same edge net out.
    drive(2'b01, '0, '0, '0, '0); tick();
    drive(2'b01, '0, 2'b01, '0, '0); tick();
    drive('0, 2'b01, '0, '0, 2'b10); tick();
    check("t7_net", 32'(bus.occupancy), 0);
    drive('0, '0, '0, '0, '0); tick();

    // Pseudo-random tail checked against the model only.
    for (int k = 0; k < 300; k++) begin
      drive(N'($urandom), N'($urandom), N'($urandom), N'($urandom),
            N'($urandom_range(0, 3) == 0 ? $urandom : 0));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
